// File: rtl/key_pkg.sv
// Shared types and constants for the PS/2 keyboard port on the key I/O slot.
package key_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_state_t;

  // One received scan-code byte, handed from the framer to the FIFO
  typedef struct packed {
    logic       push;
    logic [7:0] code;
  } key_push_t;

  localparam int          KEY_VALID_BIT = 15;
  localparam int          KEY_OVF_BIT   = 14;
  localparam logic [15:0] KEY_IO_ADDR   = 16'hFFFF;

endpackage

// File: rtl/ps2_rx.sv
// PS/2 receiver: synchronises the raw pins, detects falling clock edges and
// assembles start/8 data/odd parity/stop frames into bytes.
module ps2_rx
  import key_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic      clock,
  input  logic      reset_n,
  input  logic      ps2_clk,
  input  logic      ps2_data,
  output key_push_t rx
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  // [1:0] is the synchroniser, [2] is the previous synchronised sample
  logic [2:0]    clk_pipe;
  logic [1:0]    data_pipe;
  logic          fall;
  logic          din;

  ps2_state_t    state, next_state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par_bit;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_hit;
  logic          frame_ok;

  assign fall    = clk_pipe[2] & ~clk_pipe[1];
  assign din     = data_pipe[1];
  assign tmo_hit = (state != IDLE) && !fall && (tmo_cnt == TMO_LAST);

  // Pin synchronisers; reset high so leaving reset never looks like an edge
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_pipe  <= '1;
      data_pipe <= '1;
    end else begin
      clk_pipe  <= {clk_pipe[1:0], ps2_clk};
      data_pipe <= {data_pipe[0], ps2_data};
    end
  end

  // Framer state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  // Framer next state: advance one field per falling edge, abort on timeout
  always_comb begin
    next_state = state;
    if (tmo_hit) begin
      next_state = IDLE;
    end else if (fall) begin
      unique case (state)
        IDLE:    if (!din) next_state = DATA;
        DATA:    if (bit_cnt == 3'd7) next_state = PARITY;
        PARITY:  next_state = STOP;
        STOP:    next_state = IDLE;
        default: next_state = IDLE;
      endcase
    end
  end

  // Framer output: a frame is good on a high stop bit with odd overall parity
  always_comb begin
    frame_ok = (state == STOP) && fall && din && (^{shreg, par_bit});
  end

  // Bit counter, shift register, parity latch and inactivity timer
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt <= '0;
      shreg   <= '0;
      par_bit <= 1'b0;
      tmo_cnt <= '0;
    end else begin
      if (state == IDLE || fall || tmo_hit) tmo_cnt <= '0;
      else                                  tmo_cnt <= tmo_cnt + 1'b1;

      if (fall) begin
        unique case (state)
          IDLE:    bit_cnt <= '0;
          DATA: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          PARITY:  par_bit <= din;
          default: ;
        endcase
      end
    end
  end

  // Registered push so the FIFO sees a clean one-cycle strobe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rx <= '0;
    end else begin
      rx.push <= frame_ok;
      if (frame_ok) rx.code <= shreg;
    end
  end

endmodule

// File: rtl/ps2_key_port.sv
// Keyboard port: PS/2 receiver feeding a small scan-code FIFO, read by the
// CPU as {valid, overflow, 6'b0, head}. Writes from the CPU have no effect.
module ps2_key_port
  import key_pkg::*;
#(
  parameter int DEPTH          = 8,     // power of two, >= 2
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  input  logic        pop,
  output logic [15:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  key_push_t               rx;
  logic [DEPTH-1:0][7:0]   mem;
  logic [AW:0]             wr_ptr, rd_ptr;
  logic                    empty, full;
  logic                    rd_en, wr_en, ovf_set;
  logic                    overflow;

  ps2_rx #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rx (
    .clock    (clock),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .rx       (rx)
  );

  // Extra pointer bit separates full from empty when the indices match
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  // A pop frees the head slot in the same cycle, so push-on-full is legal then
  assign rd_en   = pop & ~empty;
  assign wr_en   = rx.push & (~full | rd_en);
  assign ovf_set = rx.push & full & ~rd_en;

  // Pointer and sticky overflow flag update
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      if (ovf_set)    overflow <= 1'b1;
      else if (rd_en) overflow <= 1'b0;
    end
  end

  // Entry storage; contents are masked by empty, so no reset is needed
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_ptr[AW-1:0]] <= rx.code;
  end

  // Read word packing straight from registered FIFO state
  always_comb begin
    rdata                = '0;
    rdata[KEY_VALID_BIT] = ~empty;
    rdata[KEY_OVF_BIT]   = overflow;
    if (!empty) rdata[7:0] = mem[rd_ptr[AW-1:0]];
  end

endmodule
